// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the data-RAM arbiter
package mem_arb_pkg;
    localparam int MEM_ADDR_W = 24;
    localparam int MEM_DATA_W = 16;
    typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_t;
    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;
endpackage

// File: rtl/risc8_ram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin chooser with bounded ownership hold
module rr_arb2
    import mem_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    owner_t        owner, owner_nxt;
    logic          last, last_nxt, keep, pick;
    logic [HW-1:0] hold, hold_nxt;
    logic [1:0]    req_q;
    // grant choice and next arbitration state; nothing is granted while in reset
    always_comb begin
        req_q     = rst ? req : 2'b00;
        keep      = owner != OWN_NONE && hold < HW'(MAX_HOLD);
        pick      = req_q == 2'b01 ? 1'b0 :
                    req_q == 2'b10 ? 1'b1 :
                    keep ? owner == OWN_P1 : ~last;
        gnt       = req_q == 2'b00 ? 2'b00 : pick ? 2'b10 : 2'b01;
        owner_nxt = req_q == 2'b00 ? OWN_NONE : pick ? OWN_P1 : OWN_P0;
        hold_nxt  = req_q == 2'b00 ? '0 :
                    owner_nxt != owner ? HW'(1) :
                    hold == HW'(MAX_HOLD) ? hold : hold + 1'b1;
        last_nxt  = req_q == 2'b00 ? last : pick;
    end
    // arbitration state; last starts at 1 so port 0 wins the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner <= OWN_NONE;
            hold  <= '0;
            last  <= 1'b1;
        end else begin
            owner <= owner_nxt;
            hold  <= hold_nxt;
            last  <= last_nxt;
        end
    end
endmodule

// File: rtl/risc8_ram_arbiter.sv
// risc8_ram_arbiter: shares one sync-read data RAM between the CPU and a secondary master
module risc8_ram_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);
    logic [1:0]        gnt;
    logic              any_gnt, rd_vld, rd_port;
    logic [ADDR_W-1:0] held_addr;
    logic [DATA_W-1:0] held_wdata;
    mem_req_t          sel;

    rr_arb2 #(.MAX_HOLD(MAX_HOLD)) u_arb (
        .clk (clk),
        .rst (rst),
        .req ({p1_req, p0_req}),
        .gnt (gnt)
    );

    // route the granted port to the RAM; address and data stay put when idle
    always_comb begin
        sel         = gnt[1] ? {p1_we, p1_addr, p1_wdata} : {p0_we, p0_addr, p0_wdata};
        any_gnt     = |gnt;
        p0_gnt      = gnt[0];
        p1_gnt      = gnt[1];
        mem_wr_en   = any_gnt & sel.we;
        mem_rd_en   = any_gnt & ~sel.we;
        mem_addr    = any_gnt ? sel.addr : held_addr;
        mem_wr_data = any_gnt ? sel.wdata : held_wdata;
        p0_rvalid   = rd_vld & ~rd_port;
        p1_rvalid   = rd_vld & rd_port;
        p0_rdata    = p0_rvalid ? mem_rd_data : '0;
        p1_rdata    = p1_rvalid ? mem_rd_data : '0;
    end

    // remember the last issued address/data and which port owns the returning read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_addr  <= '0;
            held_wdata <= '0;
            rd_vld     <= 1'b0;
            rd_port    <= 1'b0;
        end else begin
            if (any_gnt) begin
                held_addr  <= sel.addr;
                held_wdata <= sel.wdata;
            end
            rd_vld  <= any_gnt & ~sel.we;
            rd_port <= gnt[1];
        end
    end
endmodule

// File: tb/tb_risc8_ram_arbiter.sv
// tb_risc8_ram_arbiter: randomized and directed checks against a behavioural arbiter model
module tb_risc8_ram_arbiter;
    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0, rst = 1'b0;
    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [23:0] p0_addr = 0, p1_addr = 0;
    logic [15:0] p0_wdata = 0, p1_wdata = 0;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [15:0] p0_rdata, p1_rdata;
    logic [23:0] mem_addr;
    logic        mem_wr_en, mem_rd_en;
    logic [15:0] mem_wr_data;
    logic [15:0] mem_rd_data = 0;

    logic [15:0] ram [256];
    logic        pl_en = 0;
    logic [7:0]  pl_a = 0;
    logic [15:0] pl_d = 0;

    int n_checks = 0, n_errors = 0;

    logic [15:0] exp_ram [256];
    int          m_owner, m_hold, m_last;
    logic        m_pend, m_pport;
    logic [15:0] m_pdata, m_wdata;
    logic [23:0] m_addr;
    int          obs_g, rv1_cnt;
    logic [8:0]  seq;

    risc8_ram_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) ram[pl_a] <= pl_d;
        else if (mem_wr_en) ram[mem_addr[7:0]] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= ram[mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1; m_hold = 0; m_last = 1;
        m_pend = 0; m_pport = 0; m_pdata = 0;
        m_addr = 0; m_wdata = 0;
    endfunction

    function automatic int exp_grant();
        if (p0_req && !p1_req) return 0;
        if (p1_req && !p0_req) return 1;
        if (!p0_req && !p1_req) return -1;
        if (m_owner >= 0 && m_hold < MAX_HOLD) return m_owner;
        return 1 - m_last;
    endfunction

    task automatic step();
        int          g;
        logic        gwe;
        logic [23:0] ga;
        logic [15:0] gd;
        g   = exp_grant();
        gwe = (g == 1) ? p1_we : p0_we;
        ga  = (g == 1) ? p1_addr : p0_addr;
        gd  = (g == 1) ? p1_wdata : p0_wdata;
        @(negedge clk);
        obs_g = p1_gnt ? 1 : p0_gnt ? 0 : -1;
        if (p1_rvalid) rv1_cnt++;
        check("p0_gnt", p0_gnt, g == 0);
        check("p1_gnt", p1_gnt, g == 1);
        check("one_gnt", p0_gnt & p1_gnt, 0);
        check("mem_rd_en", mem_rd_en, g >= 0 && !gwe);
        check("mem_wr_en", mem_wr_en, g >= 0 && gwe);
        check("mem_addr", mem_addr, g >= 0 ? ga : m_addr);
        check("mem_wr_data", mem_wr_data, g >= 0 ? gd : m_wdata);
        check("p0_rvalid", p0_rvalid, m_pend && !m_pport);
        check("p1_rvalid", p1_rvalid, m_pend && m_pport);
        check("p0_rdata", p0_rdata, (m_pend && !m_pport) ? m_pdata : 16'h0);
        check("p1_rdata", p1_rdata, (m_pend && m_pport) ? m_pdata : 16'h0);
        @(posedge clk);
        m_pend  = g >= 0 && !gwe;
        m_pport = g == 1;
        if (g >= 0) begin
            m_pdata = exp_ram[ga[7:0]];
            if (gwe) exp_ram[ga[7:0]] = gd;
            m_addr  = ga;
            m_wdata = gd;
            if (g == m_owner) m_hold = (m_hold < MAX_HOLD) ? m_hold + 1 : MAX_HOLD;
            else begin m_owner = g; m_hold = 1; end
            m_last = g;
        end else begin
            m_owner = -1; m_hold = 0;
        end
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 0;
        model_reset();
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check("rst_p0_gnt", p0_gnt, 0);
        check("rst_p1_gnt", p1_gnt, 0);
        check("rst_p0_rvalid", p0_rvalid, 0);
        check("rst_p1_rvalid", p1_rvalid, 0);
        check("rst_strobes", {mem_wr_en, mem_rd_en}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wr_data", mem_wr_data, 0);
        check("rst_rdata", {p0_rdata, p1_rdata}, 0);
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) exp_ram[i] = 16'($urandom);
        exp_ram[8'h10] = 16'hBEEF;
        exp_ram[8'h20] = 16'hA020;
        exp_ram[8'h21] = 16'hA021;
        exp_ram[8'h22] = 16'hA022;
        model_reset();
        @(posedge clk);
        #1;
        pl_en = 1;
        for (int i = 0; i < 256; i++) begin
            pl_a = 8'(i);
            pl_d = exp_ram[i];
            @(posedge clk);
            #1;
        end
        pl_en = 0;

        do_reset(2);
        repeat (5) step();

        p0_req = 1; p0_we = 0; p0_addr = 24'h000010;
        step();
        p0_req = 0;
        step();

        do_reset(1);
        p0_req = 1; p0_we = 1; p0_addr = 24'h1; p0_wdata = 16'h1111;
        p1_req = 1; p1_we = 1; p1_addr = 24'h2; p1_wdata = 16'h2222;
        step();
        check("first_tie_p0", obs_g, 0);
        p0_req = 0;
        step();
        check("second_p1", obs_g, 1);
        p1_req = 0;
        step();
        check("ram1", ram[1], 16'h1111);
        check("ram2", ram[2], 16'h2222);

        do_reset(1);
        p0_req = 1; p0_we = 0; p0_addr = 24'h30;
        p1_req = 1; p1_we = 0; p1_addr = 24'h31;
        for (int i = 0; i < 9; i++) begin
            step();
            seq[i] = obs_g == 1;
        end
        check("hold_pattern", seq, 9'b011110000);
        p0_req = 0; p1_req = 0;
        step();

        p1_req = 1; p1_we = 0; rv1_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            p1_addr = 24'h20 + 24'(i);
            step();
        end
        p1_req = 0;
        step();
        check("b2b_rvalid_cnt", rv1_cnt, 3);

        p0_req = 1; p0_we = 0; p0_addr = 24'h10;
        @(negedge clk);
        check("midrd_gnt", p0_gnt, 1);
        rst = 0;
        #1;
        check("midrd_rst_gnt", p0_gnt, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
        p0_req = 0;
        step();
        check("midrd_no_rvalid", p0_rvalid, 0);
        p0_req = 1; p0_we = 1; p0_addr = 24'h5; p0_wdata = 16'h5555;
        p1_req = 1; p1_we = 1; p1_addr = 24'h6; p1_wdata = 16'h6666;
        step();
        check("restart_p0", obs_g, 0);

        for (int i = 0; i < 400; i++) begin
            p0_req   = $urandom_range(9) < 6;
            p0_we    = 1'($urandom);
            p0_addr  = 24'($urandom_range(255));
            p0_wdata = 16'($urandom);
            p1_req   = $urandom_range(9) < 6;
            p1_we    = 1'($urandom);
            p1_addr  = 24'($urandom_range(255));
            p1_wdata = 16'($urandom);
            step();
        end
        p0_req = 0; p1_req = 0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
